// File: rtl/pe_mac_drain.sv
// Drains one column of PE_MAC accumulators: captures them on i_start, clears the PEs,
// then streams rounded/saturated 8-bit results over valid/ready.
module pe_mac_drain #(
    parameter int N     = 4,
    parameter int ACC_W = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_start,
    input  logic [N*ACC_W-1:0]   i_mac,
    output logic                 o_clr,
    output logic                 o_busy,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [OUT_W-1:0]     o_data,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_last,
    output logic                 o_drop
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(N - 1);
    localparam logic signed [ACC_W:0]  ROUND    = (ACC_W + 1)'(1 << (SHIFT - 1));
    localparam logic signed [ACC_W:0]  SAT_MAX  = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0]  SAT_MIN  = -SAT_MAX - (ACC_W + 1)'(1);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic [ACC_W-1:0]   cap_buf [N];
    logic               capture;
    logic               clr_q;
    logic               clr_next;
    logic               drop_q;
    logic               drop_next;
    logic               fire;

    logic [ACC_W-1:0]        sel_word;
    logic signed [ACC_W:0]   ext_word;
    logic signed [ACC_W:0]   rounded;
    logic signed [ACC_W:0]   shifted;
    logic [OUT_W-1:0]        q_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            idx    <= '0;
            clr_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            clr_q  <= clr_next;
            drop_q <= drop_next;
        end
    end

    // A start arriving on the final transfer edge is a legal back-to-back capture;
    // any other start during SEND would overwrite unsent data and is dropped.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        capture    = 1'b0;
        clr_next   = 1'b0;
        drop_next  = 1'b0;
        fire       = (state == SEND) && i_ready;
        case (state)
            IDLE: begin
                if (i_start) begin
                    capture    = 1'b1;
                    clr_next   = 1'b1;
                    idx_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (fire && (idx == LAST_IDX)) begin
                    idx_next = '0;
                    if (i_start) begin
                        capture    = 1'b1;
                        clr_next   = 1'b1;
                        state_next = SEND;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (fire) begin
                        idx_next = idx + IDX_W'(1);
                    end
                    if (i_start) begin
                        drop_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < N; k++) begin
                cap_buf[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < N; k++) begin
                cap_buf[k] <= i_mac[k*ACC_W +: ACC_W];
            end
        end
    end

    // One extra bit of headroom makes the round-half-up add overflow-free.
    always_comb begin
        sel_word = cap_buf[idx];
        ext_word = $signed({sel_word[ACC_W-1], sel_word});
        rounded  = ext_word + ROUND;
        shifted  = rounded >>> SHIFT;
        if (shifted > SAT_MAX) begin
            q_data = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            q_data = SAT_MIN[OUT_W-1:0];
        end else begin
            q_data = shifted[OUT_W-1:0];
        end
    end

    assign o_valid = (state == SEND);
    assign o_busy  = (state == SEND);
    assign o_data  = (state == SEND) ? q_data : '0;
    assign o_idx   = idx;
    assign o_last  = (state == SEND) && (idx == LAST_IDX);
    assign o_clr   = clr_q;
    assign o_drop  = drop_q;

endmodule

// File: tb/tb_pe_mac_drain.sv
// Directed bench for pe_mac_drain: reset, basic drain, saturation, backpressure,
// overrun/back-to-back capture and asynchronous reset mid-drain.
module tb_pe_mac_drain;

    localparam int N     = 4;
    localparam int ACC_W = 16;
    localparam int OUT_W = 8;
    localparam int SHIFT = 4;

    logic               clk;
    logic               rstn;
    logic               i_start;
    logic [N*ACC_W-1:0] i_mac;
    logic               o_clr;
    logic               o_busy;
    logic               o_valid;
    logic               i_ready;
    logic [OUT_W-1:0]   o_data;
    logic [1:0]         o_idx;
    logic               o_last;
    logic               o_drop;

    int total = 0;
    int bad   = 0;

    // Input vectors (k3 in the MSBs) and their hand-computed results (beat 0 in the LSBs)
    localparam logic [63:0] MAC_BASIC = {16'h0014, 16'h0018, 16'h0010, 16'h0000};
    localparam logic [31:0] EXP_BASIC = {8'h01, 8'h02, 8'h01, 8'h00};
    localparam logic [63:0] MAC_SAT   = {16'hFFF7, 16'hFFF8, 16'h8000, 16'h7FFF};
    localparam logic [31:0] EXP_SAT   = {8'hFF, 8'h00, 8'h80, 8'h7F};
    localparam logic [63:0] MAC_BP    = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
    localparam logic [31:0] EXP_BP    = {8'h04, 8'h03, 8'h02, 8'h01};

    pe_mac_drain #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_start (i_start),
        .i_mac   (i_mac),
        .o_clr   (o_clr),
        .o_busy  (o_busy),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_idx   (o_idx),
        .o_last  (o_last),
        .o_drop  (o_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [63:0] mac, input logic ready);
        i_start = start;
        i_mac   = mac;
        i_ready = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_clr"},   32'(o_clr),   32'd0);
        checkOutput({tag, "_busy"},  32'(o_busy),  32'd0);
        checkOutput({tag, "_valid"}, 32'(o_valid), 32'd0);
        checkOutput({tag, "_data"},  32'(o_data),  32'd0);
        checkOutput({tag, "_idx"},   32'(o_idx),   32'd0);
        checkOutput({tag, "_last"},  32'(o_last),  32'd0);
        checkOutput({tag, "_drop"},  32'(o_drop),  32'd0);
    endtask

    task automatic checkBeat(input string tag, input int k, input logic [7:0] exp_data,
                             input logic exp_clr, input logic exp_drop);
        checkOutput($sformatf("%s_valid%0d", tag, k), 32'(o_valid), 32'd1);
        checkOutput($sformatf("%s_busy%0d",  tag, k), 32'(o_busy),  32'd1);
        checkOutput($sformatf("%s_idx%0d",   tag, k), 32'(o_idx),   32'(k));
        checkOutput($sformatf("%s_data%0d",  tag, k), 32'(o_data),  32'(exp_data));
        checkOutput($sformatf("%s_last%0d",  tag, k), 32'(o_last),  32'(k == N - 1));
        checkOutput($sformatf("%s_clr%0d",   tag, k), 32'(o_clr),   32'(exp_clr));
        checkOutput($sformatf("%s_drop%0d",  tag, k), 32'(o_drop),  32'(exp_drop));
    endtask

    // Called with beat 0 already visible and i_ready high; ends back in IDLE.
    task automatic drainCheck(input string tag, input logic [31:0] exp, input logic clr_first);
        for (int k = 0; k < N; k++) begin
            checkBeat(tag, k, exp[k*8 +: 8], (k == 0) ? clr_first : 1'b0, 1'b0);
            tick();
        end
        checkOutput({tag, "_end_valid"}, 32'(o_valid), 32'd0);
        checkOutput({tag, "_end_busy"},  32'(o_busy),  32'd0);
        checkOutput({tag, "_end_clr"},   32'(o_clr),   32'd0);
    endtask

    initial begin
        logic [7:0] exp_idx_seq [8];
        int valid_cycles;

        // Reset and idle
        rstn = 1'b1;
        applyStimulus(1'b0, {$urandom, $urandom}, 1'b0);
        #1 rstn = 1'b0;
        #2;
        checkIdleOutputs("reset");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checkOutput($sformatf("idle_valid%0d", c), 32'(o_valid), 32'd0);
            checkOutput($sformatf("idle_clr%0d", c),   32'(o_clr),   32'd0);
        end

        // Basic drain, ready held high
        applyStimulus(1'b1, MAC_BASIC, 1'b1);
        tick();
        applyStimulus(1'b0, {$urandom, $urandom}, 1'b1);
        drainCheck("basic", EXP_BASIC, 1'b1);

        // Saturation and rounding
        applyStimulus(1'b1, MAC_SAT, 1'b1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1);
        drainCheck("sat", EXP_SAT, 1'b1);

        // Backpressure: ready low for the three cycles following the first beat
        exp_idx_seq = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd0};
        applyStimulus(1'b1, MAC_BP, 1'b1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1);
        valid_cycles = 0;
        for (int c = 0; c < 20 && o_valid; c++) begin
            valid_cycles++;
            if (c < 8) begin
                checkOutput($sformatf("bp_idx%0d", c),  32'(o_idx),  32'(exp_idx_seq[c]));
                checkOutput($sformatf("bp_data%0d", c), 32'(o_data), 32'(EXP_BP[exp_idx_seq[c][1:0]*8 +: 8]));
            end
            i_ready = !(c >= 1 && c <= 3);
            tick();
        end
        checkOutput("bp_cycles", 32'(valid_cycles), 32'(N + 3));
        checkOutput("bp_end_valid", 32'(o_valid), 32'd0);

        // Overrun at idx 1, then back-to-back start on the final transfer edge
        applyStimulus(1'b1, MAC_BASIC, 1'b1);
        tick();
        applyStimulus(1'b0, MAC_SAT, 1'b1);
        checkBeat("ovr", 0, EXP_BASIC[7:0], 1'b1, 1'b0);
        tick();
        checkBeat("ovr", 1, EXP_BASIC[15:8], 1'b0, 1'b0);
        applyStimulus(1'b1, MAC_SAT, 1'b1);
        tick();
        applyStimulus(1'b0, MAC_SAT, 1'b1);
        checkBeat("ovr", 2, EXP_BASIC[23:16], 1'b0, 1'b1);
        tick();
        checkBeat("ovr", 3, EXP_BASIC[31:24], 1'b0, 1'b0);
        applyStimulus(1'b1, MAC_SAT, 1'b1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1);
        drainCheck("b2b", EXP_SAT, 1'b1);

        // Asynchronous reset at idx 2 with ready low
        applyStimulus(1'b1, MAC_BP, 1'b1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1);
        tick();
        tick();
        checkOutput("rst_mid_idx_before", 32'(o_idx), 32'd2);
        i_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        checkIdleOutputs("rst_mid");
        tick();
        checkIdleOutputs("rst_hold");
        rstn = 1'b1;
        tick();
        applyStimulus(1'b1, MAC_BASIC, 1'b1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1);
        drainCheck("restart", EXP_BASIC, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_mac_drain.md
Name: pe_mac_drain

Overview:
- Result-side counterpart of the PE_MAC array. It reads the 16-bit accumulators of one column of N PE_MAC instances once a tile finishes.
- Requantizes each value to 8 bits using a rounding arithmetic right shift followed by saturation.
- Streams the results out one per transfer on a valid/ready interface toward the output buffer.
- Pulses a clear to the PEs as soon as their accumulators have been captured, so the next tile can start while draining continues.

Parameters:
- N, 4, number of PE accumulators in the column (N >= 2).
- ACC_W, 16, accumulator width (matches PE_MAC o_mac).
- OUT_W, 8, output element width.
- SHIFT, 4, requantization right shift (1 <= SHIFT < ACC_W).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse: all PE accumulators in i_mac are final.
- i_mac  in  N*ACC_W  packed accumulators; PE k occupies bits [k*ACC_W +: ACC_W]; signed two's complement.
- o_clr  out  1  one-cycle pulse to the PEs to clear their accumulators.
- o_busy  out  1  high while captured data is still being sent.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  downstream accepts o_data.
- o_data  out  OUT_W  requantized signed result.
- o_idx  out  $clog2(N)  PE index of the current o_data.
- o_last  out  1  high with o_valid on index N-1.
- o_drop  out  1  one-cycle pulse: i_start was ignored.

Behaviour:
- Reset (async, rstn=0):
  - State = IDLE; idx = 0; capture buffer = 0.
  - All outputs 0: o_clr, o_busy, o_valid, o_data, o_idx, o_last, o_drop.
- States: IDLE, SEND.
- IDLE:
  - i_start=1 → capture all N words of i_mac into the buffer; o_clr=1 the next cycle (exactly one cycle).
  - Then idx=0 and go to SEND.
  - i_start=0 → stay in IDLE.
- SEND:
  - o_valid=1 and o_busy=1.
  - o_valid rises the cycle after i_start, in the same cycle as o_clr.
  - o_data = Q(buf[idx]); o_idx = idx; o_last = (idx == N-1).
  - All outputs are registered or decoded from registers; there is no combinational path from i_mac or i_ready to any output.
- Transfer occurs on a clock edge with o_valid=1 and i_ready=1.
  - Transfer with idx < N-1 → idx+1.
  - Transfer with idx = N-1 → go to IDLE, o_valid=0, idx=0.
- Backpressure:
  - While o_valid=1 and i_ready=0, o_data, o_idx and o_last hold stable.
  - The buffer is not modified.
- i_start while in SEND, except on the final transfer cycle:
  - Ignored; the buffer is unchanged.
  - o_drop=1 next cycle (one cycle); no o_clr.
- i_start on the same edge as the final (idx=N-1) transfer:
  - New capture accepted; o_clr pulses.
  - Stay in SEND with idx=0, so o_valid stays high continuously with no bubble.
- Throughput: one element per cycle with i_ready held high; N elements in N cycles.
- Requantization Q(x):
  - Sign-extend x to ACC_W+1 bits.
  - Add 2^(SHIFT-1) (round half up); there is no overflow at ACC_W+1 bits.
  - Arithmetic shift right by SHIFT.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Computed combinationally from the buffer.
- Reset asserted mid-SEND: immediate return to the reset values; partially sent data is discarded; no o_clr.

Test Plan:
- Reset & idle:
  - Stimulus: rstn=0 with i_mac random.
  - Required: all outputs 0.
  - Stimulus: release reset, keep i_start=0 for 10 cycles.
  - Required: o_valid=0, o_clr=0.
- Basic drain (ready held high, SHIFT=4):
  - Stimulus: i_mac = {0x0014, 0x0018, 0x0010, 0x0000} for k=3..0, pulse i_start.
  - Required: next cycle o_clr=1 for one cycle.
  - Required: o_data = 0x00, 0x01, 0x02, 0x01 on o_idx 0..3 in 4 consecutive cycles.
  - Required: o_last only with idx 3.
- Saturation and rounding:
  - Stimulus: i_mac k0..k3 = 0x7FFF, 0x8000, 0xFFF8, 0xFFF7.
  - Required: o_data = 0x7F, 0x80, 0x00, 0xFF.
- Backpressure:
  - Stimulus: i_ready low for 3 cycles at idx=1.
  - Required: o_data and o_idx stable at idx 1 for those cycles; total drain takes N+3 cycles after o_valid rises.
- Overrun and back-to-back:
  - Stimulus: i_start at idx=1.
  - Required: o_drop pulse; data unchanged; no o_clr.
  - Stimulus: i_start on the idx=3 transfer edge.
  - Required: o_clr pulse; o_valid stays high; next o_idx=0 shows the new data.
- Reset mid-operation:
  - Stimulus: rstn=0 at idx=2 with i_ready=0.
  - Required: outputs 0 immediately (async).
  - Stimulus: after release, new i_start.
  - Required: drain restarts at idx 0.
